link_packet_engine: RTL
=======================

Name: link_packet_engine

Overview:
- Parametrised reliable packet layer between game-play logic (move/setup/game-over producers and consumers) and the 16-bit parity UART core.
- Adds features the current game-play UART handling lacks:
  - a queued TX path;
  - a per-packet 1-bit sequence number;
  - ACK generation and checking;
  - timeout/retransmit with a bounded retry count;
  - duplicate suppression and error flags.
- Game logic enqueues typed payloads and receives de-duplicated typed payloads.

Parameters:
- PKT_W, 16, UART word width; packet = {type[1:0], seq, payload[PKT_W-4:0]}.
- PAYLOAD_W, PKT_W-3, payload width (derived; must not be overridden).
- TXQ_DEPTH, 4, TX queue entries; power of two, >=2.
- ACK_TIMEOUT, 50000, cycles waited for an ACK before retransmit; 1 ms at 50 MHz.
- MAX_RETRIES, 3, retransmits after the first send before declaring failure.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- tx_req  in  1  enqueue request, accepted when tx_ready=1
- tx_type  in  2  pkt_type_t of the enqueued packet; ACK not allowed
- tx_payload  in  PAYLOAD_W  payload to enqueue
- tx_ready  out  1  queue not full
- rx_valid  out  1  one-cycle pulse, new in-order packet
- rx_type  out  2  type of delivered packet; held until next delivery
- rx_payload  out  PAYLOAD_W  payload of delivered packet; held until next delivery
- uart_tx_valid  out  1  one-cycle send strobe to the UART
- uart_tx_data  out  PKT_W  word to send
- uart_tx_busy  in  1  UART transmitter busy
- uart_rx_pending  in  1  UART holds a received word
- uart_rx_req  out  1  one-cycle pop strobe to the UART
- uart_rx_data  in  PKT_W  popped word, valid the cycle after uart_rx_req
- uart_rx_parity_err  in  1  parity flag for uart_rx_data
- link_fail  out  1  sticky; retries exhausted
- overflow  out  1  sticky; tx_req while full
- err_clear  in  1  clears link_fail and overflow, and restarts TX from T_IDLE

Behaviour:
- Reset values:
  - all outputs 0, except tx_ready=1;
  - queue empty; tx_seq=0; rx_expect_seq=0; ack_pending=0; retry_cnt=0;
  - TX FSM in T_IDLE, RX FSM in R_WAIT.
- Packet types:
  - 00 MOVE, 01 ACK, 10 SETUP, 11 GAMEOVER.
  - An ACK carries the acknowledged seq in bit PKT_W-3 and a zero payload.
- Queue:
  - Write on tx_req && tx_ready.
  - tx_req while full: ignored, overflow<=1.
  - Enqueue and dequeue in the same cycle when full: both take effect; tx_ready stays 0.
- RX FSM, 3-cycle pop:
  - R_WAIT: when uart_rx_pending=1, pulse uart_rx_req, go to R_REQ.
  - R_REQ: one idle cycle, go to R_HANDLE.
  - R_HANDLE: decode uart_rx_data, then go to R_WAIT.
- R_HANDLE decode:
  - parity_err=1: drop silently; no ACK, so the peer retransmits.
  - type ACK: raise ack_seen with the seq for one cycle to the TX FSM.
  - Other type: set ack_pending=1, ack_seq=seq.
    - If seq==rx_expect_seq: pulse rx_valid, latch rx_type/rx_payload, toggle rx_expect_seq.
    - Otherwise (duplicate): re-ACK, no delivery.
  - A new ACK request while ack_pending=1 overwrites ack_seq.
- TX arbitration, evaluated each cycle uart_tx_busy=0 and no strobe was issued the previous cycle:
  - ack_pending has priority: send {01, ack_seq, 0}, clear ack_pending.
  - Otherwise the TX FSM may send.
  - At most one uart_tx_valid per cycle.
- TX FSM:
  - T_IDLE: queue non-empty -> T_SEND, retry_cnt=0.
  - T_SEND: when granted, strobe {head.type, tx_seq, head.payload}, load the timer with ACK_TIMEOUT, go to T_WAIT.
  - T_WAIT:
    - ack_seen with seq==tx_seq: pop head, toggle tx_seq, go to T_IDLE.
    - ack_seen with a mismatched seq: ignored.
    - Timer reaches 0 and retry_cnt<MAX_RETRIES: retry_cnt+1, go to T_SEND.
    - Timer reaches 0 and retry_cnt==MAX_RETRIES: link_fail<=1, go to T_FAIL.
  - T_FAIL: holds; the queue is retained; err_clear goes to T_IDLE and resends the head with the same tx_seq.
  - ACK and timeout in the same cycle: the ACK wins.
- Timer and counter widths:
  - Timer width is $clog2(ACK_TIMEOUT+1).
  - retry_cnt width is $clog2(MAX_RETRIES+1).
  - Both saturate; neither wraps.
- err_clear with tx_req in the same cycle: the enqueue is still accepted.

Decomposition:
- Package link_pkg holds:
  - pkt_type_t enum (MOVE, ACK, SETUP, GAMEOVER);
  - link_tx_state_t (T_IDLE, T_SEND, T_WAIT, T_FAIL);
  - link_rx_state_t (R_WAIT, R_REQ, R_HANDLE);
  - packet field index localparam functions.
- One sub-module, link_fifo: synchronous FIFO with parameters WIDTH and DEPTH, ports push/pop/full/empty/head; reset uses the same asynchronous active-low scheme.

Test Plan:
- Enqueue MOVE payload 0x0ABC; the model ACKs seq 0 after 20 cycles -> one uart_tx_data=0x0ABC; pop; tx_seq=1; no retransmit.
- Enqueue SETUP 0x1000 and never ACK -> exactly 4 strobes spaced ACK_TIMEOUT apart, then link_fail=1; err_clear -> resend with seq=1.
- RX word {MOVE,0,0x0123} delivered twice -> rx_valid once with payload 0x0123, and two ACKs with seq 0.
- RX word with parity_err=1 -> no rx_valid, no ACK; the resent clean copy is delivered.
- Enqueue 5 packets with TXQ_DEPTH=4 and no ACK -> tx_ready=0 after 4; 5th dropped, overflow=1; queue order preserved after ACKs.
- Incoming data arrives while local data awaits ACK -> ACK is sent before any retransmit; both directions complete; assert reset_n mid-T_WAIT -> all outputs at reset values.

Source files
------------

// File: rtl/link_pkg.sv
// link_pkg: shared packet types, FSM states and field positions for the link packet engine.
package link_pkg;
  typedef enum logic [1:0] {MOVE = 2'b00, ACK = 2'b01, SETUP = 2'b10, GAMEOVER = 2'b11} pkt_type_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT, T_FAIL} link_tx_state_t;
  typedef enum logic [1:0] {R_WAIT, R_REQ, R_HANDLE} link_rx_state_t;
  function automatic int type_lsb(input int pkt_w);
    return pkt_w - 2;
  endfunction
  function automatic int seq_bit(input int pkt_w);
    return pkt_w - 3;
  endfunction
endpackage

// File: rtl/link_fifo.sv
// link_fifo: synchronous FIFO; push while full is accepted only alongside a pop.
module link_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr[AW-1:0]] <= data;
endmodule

// File: rtl/link_packet_engine.sv
// link_packet_engine: queued, sequenced, ACK/retransmit packet layer over the parity UART.
module link_packet_engine
  import link_pkg::*;
#(
  parameter int PKT_W       = 16,
  parameter int PAYLOAD_W   = PKT_W - 3,
  parameter int TXQ_DEPTH   = 4,
  parameter int ACK_TIMEOUT = 50000,
  parameter int MAX_RETRIES = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_req,
  input  logic [1:0]           tx_type,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic                 tx_ready,
  output logic                 rx_valid,
  output logic [1:0]           rx_type,
  output logic [PAYLOAD_W-1:0] rx_payload,
  output logic                 uart_tx_valid,
  output logic [PKT_W-1:0]     uart_tx_data,
  input  logic                 uart_tx_busy,
  input  logic                 uart_rx_pending,
  output logic                 uart_rx_req,
  input  logic [PKT_W-1:0]     uart_rx_data,
  input  logic                 uart_rx_parity_err,
  output logic                 link_fail,
  output logic                 overflow,
  input  logic                 err_clear
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  localparam int SEQ = seq_bit(PKT_W);
  localparam int TL = type_lsb(PKT_W);
  link_tx_state_t tx_state, tx_next;
  link_rx_state_t rx_state, rx_next;
  logic [PAYLOAD_W+1:0] q_head;
  logic q_full, q_empty, q_push, q_pop;
  logic tx_seq, rx_expect_seq, ack_pending, ack_seq;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry_cnt;
  logic can_send, ack_send, tx_send, ack_match, retry, give_up, timeout;
  logic rx_ok, rx_is_ack, ack_seen, rx_ack_req, rx_deliver, rx_seq;
  link_fifo #(.WIDTH(PAYLOAD_W + 2), .DEPTH(TXQ_DEPTH)) u_txq (
    .clk(clk), .reset_n(reset_n), .push(q_push), .data({tx_type, tx_payload}),
    .pop(q_pop), .full(q_full), .empty(q_empty), .head(q_head)
  );
  assign tx_ready = !q_full;
  assign q_push = tx_req && (!q_full || q_pop);
  // A strobe in flight blocks the next cycle so the UART can raise busy.
  assign can_send = !uart_tx_busy && !uart_tx_valid;
  assign ack_send = can_send && ack_pending;
  assign timeout = timer == '0;
  assign rx_seq = uart_rx_data[SEQ];
  assign rx_ok = rx_state == R_HANDLE && !uart_rx_parity_err;
  assign rx_is_ack = uart_rx_data[TL +: 2] == ACK;
  assign ack_seen = rx_ok && rx_is_ack;
  assign rx_ack_req = rx_ok && !rx_is_ack;
  assign rx_deliver = rx_ack_req && rx_seq == rx_expect_seq;
  assign uart_rx_req = rx_state == R_WAIT && uart_rx_pending;
  assign q_pop = ack_match;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) tx_state <= T_IDLE;
    else tx_state <= tx_next;
  always_comb begin
    tx_next = tx_state;
    unique case (tx_state)
      T_IDLE: if (!q_empty) tx_next = T_SEND;
      T_SEND: if (tx_send) tx_next = T_WAIT;
      T_WAIT: tx_next = ack_match ? T_IDLE : retry ? T_SEND : give_up ? T_FAIL : T_WAIT;
      default: tx_next = T_FAIL;
    endcase
    if (err_clear) tx_next = T_IDLE;
  end
  always_comb begin
    tx_send = tx_state == T_SEND && can_send && !ack_pending && !err_clear;
    ack_match = tx_state == T_WAIT && ack_seen && rx_seq == tx_seq;
    retry = tx_state == T_WAIT && !ack_match && timeout && retry_cnt < RW'(MAX_RETRIES);
    give_up = tx_state == T_WAIT && !ack_match && timeout && !retry;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      tx_seq <= 1'b0;
      timer <= '0;
      retry_cnt <= '0;
      link_fail <= 1'b0;
      overflow <= 1'b0;
      uart_tx_valid <= 1'b0;
      uart_tx_data <= '0;
    end else begin
      if (q_pop) tx_seq <= ~tx_seq;
      timer <= tx_send ? TW'(ACK_TIMEOUT) : timeout ? timer : timer - TW'(1);
      if (tx_state == T_IDLE) retry_cnt <= '0;
      else if (retry) retry_cnt <= retry_cnt + RW'(1);
      link_fail <= !err_clear && (link_fail || give_up);
      overflow <= !err_clear && (overflow || (tx_req && !q_push));
      uart_tx_valid <= ack_send || tx_send;
      if (ack_send) uart_tx_data <= {ACK, ack_seq, {PAYLOAD_W{1'b0}}};
      else if (tx_send) uart_tx_data <= {q_head[PAYLOAD_W +: 2], tx_seq, q_head[PAYLOAD_W-1:0]};
    end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rx_state <= R_WAIT;
    else rx_state <= rx_next;
  always_comb
    rx_next = rx_state == R_WAIT ? (uart_rx_pending ? R_REQ : R_WAIT) :
              rx_state == R_REQ ? R_HANDLE : R_WAIT;
  // A fresh ACK request keeps ack_pending set even while the previous ACK goes out.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      ack_pending <= 1'b0;
      ack_seq <= 1'b0;
      rx_expect_seq <= 1'b0;
      rx_valid <= 1'b0;
      rx_type <= '0;
      rx_payload <= '0;
    end else begin
      ack_pending <= rx_ack_req || (ack_pending && !ack_send);
      if (rx_ack_req) ack_seq <= rx_seq;
      rx_valid <= rx_deliver;
      if (rx_deliver) begin
        rx_type <= uart_rx_data[TL +: 2];
        rx_payload <= uart_rx_data[PAYLOAD_W-1:0];
        rx_expect_seq <= ~rx_expect_seq;
      end
    end
endmodule
